// File: rtl/restrict_sweep_ctrl_pkg.sv
// Shared types and helpers for the restriction-cube sweep controller.
// Provides the state encoding, MISR constants and the masked free-bit increment.
package restrict_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam int unsigned MAX_W = 32;

  // x^16 + x^12 + x^5 + 1
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // Forcing fixed bits to 1 lets the carry ripple straight across them.
  function automatic logic [MAX_W-1:0] masked_inc(input logic [MAX_W-1:0] cur,
                                                  input logic [MAX_W-1:0] m,
                                                  input logic [MAX_W-1:0] v);
    return (((cur | m) + MAX_W'(1)) & ~m) | (v & m);
  endfunction

endpackage

// File: rtl/restrict_sweep_ctrl_if.sv
// Harness-side bundle of the sweep controller: control, restriction cube, FUT link, status.
// The sig signal exists only when SWEEP_SIG_EN is defined.
interface restrict_sweep_ctrl_if #(
  parameter int N_IN  = 16,
  parameter int CNT_W = N_IN + 1
);
  logic             start;
  logic             abort;
  logic [N_IN-1:0]  fix_mask;
  logic [N_IN-1:0]  fix_val;
  logic [N_IN-1:0]  x_out;
  logic             y_in;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] ones_cnt;
`ifdef SWEEP_SIG_EN
  logic [15:0]      sig;
`endif

  modport master (
    output start, abort, fix_mask, fix_val, y_in,
    input  x_out, busy, done, vec_cnt, ones_cnt
`ifdef SWEEP_SIG_EN
    , input sig
`endif
  );

  modport slave (
    input  start, abort, fix_mask, fix_val, y_in,
    output x_out, busy, done, vec_cnt, ones_cnt
`ifdef SWEEP_SIG_EN
    , output sig
`endif
  );

endinterface

// File: rtl/restrict_sweep_ctrl_valid_pipe.sv
// LAT-deep shift register of issue-valid; the last stage marks the cycle y_in is sampled.
// empty_o reports that no valid will remain in the pipe after the coming edge.
module sweep_valid_pipe #(
  parameter int LAT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic valid_i,
  output logic sample_o,
  output logic empty_o
);

  generate
    if (LAT == 0) begin : g_comb
      logic unused_ok;
      assign unused_ok = ^{clk, rst, flush_i};
      assign sample_o  = valid_i;
      assign empty_o   = 1'b1;
    end else begin : g_pipe
      logic [LAT-1:0] stg_q, stg_d;

      always_comb begin
        stg_d = '0;
        if (!flush_i) begin
          stg_d = (stg_q << 1) | LAT'(valid_i);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          stg_q <= '0;
        end else begin
          stg_q <= stg_d;
        end
      end

      assign sample_o = stg_q[LAT-1];
      assign empty_o  = (stg_d == '0);
    end
  endgenerate

endmodule

// File: rtl/restrict_sweep_ctrl.sv
// Sweeps every input vector inside a restriction cube through an external function and
// counts sampled vectors and onset hits. Optional MISR signature output under SWEEP_SIG_EN.
module restrict_sweep_ctrl
  import restrict_sweep_pkg::*;
#(
  parameter int N_IN  = 16,
  parameter int LAT   = 0,
  parameter int CNT_W = N_IN + 1
) (
  input logic                 clk,
  input logic                 rst,
  restrict_sweep_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [N_IN-1:0]  m_q, m_d;
  logic [N_IN-1:0]  v_q, v_d;
  logic [N_IN-1:0]  x_q, x_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] ones_q, ones_d;

  logic start_ok;
  logic last_vec;
  logic issue;
  logic sample;
  logic sample_ok;
  logic drained;

  assign start_ok  = bus.start && !bus.abort && (state_q == IDLE || state_q == DONE);
  assign last_vec  = ((x_q | m_q) == '1);
  assign issue     = (state_q == RUN) && !bus.abort;
  // A sample landing in the abort cycle belongs to a discarded sweep.
  assign sample_ok = sample && !bus.abort;

  sweep_valid_pipe #(.LAT(LAT)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (bus.abort),
    .valid_i  (issue),
    .sample_o (sample),
    .empty_o  (drained)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    v_d     = v_q;
    x_d     = x_q;
    vec_d   = vec_q;
    ones_d  = ones_q;

    if (sample_ok) begin
      vec_d  = vec_q + CNT_W'(1);
      ones_d = ones_q + CNT_W'(bus.y_in);
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (start_ok) begin
          m_d     = bus.fix_mask;
          v_d     = bus.fix_val;
          x_d     = bus.fix_val & bus.fix_mask;
          vec_d   = '0;
          ones_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (last_vec) begin
          state_d = (LAT == 0) ? DONE : DRAIN;
        end else begin
          x_d = N_IN'(masked_inc(MAX_W'(x_q), MAX_W'(m_q), MAX_W'(v_q)));
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (drained) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      v_q     <= '0;
      x_q     <= '0;
      vec_q   <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      v_q     <= v_d;
      x_q     <= x_d;
      vec_q   <= vec_d;
      ones_q  <= ones_d;
    end
  end

  assign bus.x_out    = x_q;
  assign bus.busy     = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done     = (state_q == DONE);
  assign bus.vec_cnt  = vec_q;
  assign bus.ones_cnt = ones_q;

`ifdef SWEEP_SIG_EN
  logic [15:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (start_ok) begin
      sig_d = MISR_SEED;
    end else if (sample_ok) begin
      sig_d = {sig_q[14:0], 1'b0} ^ ((sig_q[15] ^ bus.y_in) ? MISR_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign bus.sig = sig_q;
`endif

endmodule

// File: tb/tb_restrict_sweep_ctrl.sv
// Scoreboard bench: a combinational (LAT=0) and a pipelined (LAT=2) controller run the
// same sweeps; expectations come from brute-force enumeration of the restriction cube.
module tb_restrict_sweep_ctrl;
  localparam int N  = 16;
  localparam int CW = 17;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] fm = '0;
  logic [15:0] fv = '0;
  int          fsel = 0;
  logic [15:0] key = '0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  function automatic logic fmodel(input logic [15:0] x, input int sel, input logic [15:0] k);
    case (sel)
      0:       return x[0];
      1:       return 1'b1;
      2:       return x[3] & x[9];
      default: return ^(x & k);
    endcase
  endfunction

  restrict_sweep_ctrl_if #(.N_IN(N), .CNT_W(CW)) bus0 ();
  restrict_sweep_ctrl_if #(.N_IN(N), .CNT_W(CW)) bus2 ();

  assign bus0.start = start;
  assign bus0.abort = abort;
  assign bus0.fix_mask = fm;
  assign bus0.fix_val = fv;
  assign bus2.start = start;
  assign bus2.abort = abort;
  assign bus2.fix_mask = fm;
  assign bus2.fix_val = fv;

  assign bus0.y_in = fmodel(bus0.x_out, fsel, key);
  logic d1 = 1'b0, d2 = 1'b0;
  always @(posedge clk) begin
    d1 <= fmodel(bus2.x_out, fsel, key);
    d2 <= d1;
  end
  assign bus2.y_in = d2;

  restrict_sweep_ctrl #(.N_IN(N), .LAT(0), .CNT_W(CW)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0.slave));
  restrict_sweep_ctrl #(.N_IN(N), .LAT(2), .CNT_W(CW)) u_dut2 (
    .clk (clk), .rst (rst), .bus (bus2.slave));

  typedef struct {
    logic        dn;
    logic [31:0] vec;
    logic [31:0] ones;
    logic        chk_x;
    logic [15:0] x;
    int          bc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q2[$];
  logic [15:0] xq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic end_cmp(input string tag, input exp_t e, input logic dn,
                         input logic [31:0] vec, input logic [31:0] ones,
                         input logic [15:0] x, input int bc);
    check({tag, "_done"}, 32'(dn), 32'(e.dn));
    check({tag, "_vec"}, vec, e.vec);
    check({tag, "_ones"}, ones, e.ones);
    check({tag, "_busy_cycles"}, bc, e.bc);
    if (e.chk_x) check({tag, "_x_final"}, 32'(x), 32'(e.x));
  endtask

  // Monitor for the LAT=0 controller: vector order while busy, results when busy drops.
  logic pb0 = 1'b0;
  int   bc0 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (bus0.busy) begin
      bc0++;
      if (xq.size() == 0) begin
        total++; bad++;
        $display("FAIL dut0_xseq: got %0h expected no vector", bus0.x_out);
      end else begin
        check("dut0_xseq", 32'(bus0.x_out), 32'(xq.pop_front()));
      end
    end else if (pb0) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL dut0_end: got unexpected end of sweep expected none");
      end else begin
        e = q0.pop_front();
        end_cmp("dut0", e, bus0.done, 32'(bus0.vec_cnt), 32'(bus0.ones_cnt), bus0.x_out, bc0);
      end
      bc0 = 0;
    end
    pb0 = bus0.busy;
  end

  logic pb2 = 1'b0;
  int   bc2 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (bus2.busy) begin
      bc2++;
    end else if (pb2) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL dut2_end: got unexpected end of sweep expected none");
      end else begin
        e = q2.pop_front();
        end_cmp("dut2", e, bus2.done, 32'(bus2.vec_cnt), 32'(bus2.ones_cnt), bus2.x_out, bc2);
      end
      bc2 = 0;
    end
    pb2 = bus2.busy;
  end

  task automatic wait_idle(input int budget);
    int c = 0;
    while ((q0.size() != 0 || q2.size() != 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    if (q0.size() != 0 || q2.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout: got %0d/%0d pending results expected 0", q0.size(), q2.size());
      q0.delete(); q2.delete(); xq.delete();
    end
    check("xseq_consumed", xq.size(), 0);
    xq.delete();
  endtask

  // ab>0: abort (together with a start pulse) after ab counted cycles.
  task automatic run_sweep(input logic [15:0] m, input logic [15:0] v, input int sel,
                           input logic [15:0] k, input int ab, input bit remid,
                           input bit rstmid);
    logic [15:0] xs[$];
    int          pre[$];
    logic [15:0] xx;
    int          n, lim, acc;
    exp_t        e0, e2;
    for (int i = 0; i < 65536; i++) begin
      xx = 16'(i);
      if ((xx & m) == (v & m)) xs.push_back(xx);
    end
    n = xs.size();
    acc = 0;
    pre.push_back(0);
    for (int i = 0; i < n; i++) begin
      acc += int'(fmodel(xs[i], sel, k));
      pre.push_back(acc);
    end
    @(negedge clk);
    fm = m; fv = v; fsel = sel; key = k;
    e0 = '{dn: 1'b1, vec: 32'(n), ones: 32'(pre[n]), chk_x: 1'b1, x: (v & m) | ~m, bc: n};
    e2 = e0;
    e2.bc = n + 2;
    lim = n;
    if (ab > 0) begin
      lim = ab + 1;
      e0 = '{dn: 1'b0, vec: 32'(ab), ones: 32'(pre[ab]), chk_x: 1'b0, x: '0, bc: ab + 1};
      e2 = '{dn: 1'b0, vec: 32'(ab - 2), ones: 32'(pre[ab-2]), chk_x: 1'b0, x: '0, bc: ab + 1};
    end else if (rstmid) begin
      e2 = '{dn: 1'b0, vec: 0, ones: 0, chk_x: 1'b1, x: '0, bc: 2};
    end
    for (int j = 0; j < lim; j++) xq.push_back(xs[j]);
    q0.push_back(e0);
    q2.push_back(e2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (ab > 0) begin
      repeat (ab) @(negedge clk);
      abort = 1'b1; start = 1'b1;
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
    end else if (rstmid) begin
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end else if (remid) begin
      repeat (2) @(negedge clk);
      start = 1'b1; fm = ~m; fv = ~v;
      @(negedge clk);
      start = 1'b0; fm = m; fv = v;
    end
    wait_idle(n + 40);
    if (ab == 0 && !rstmid) begin
      check("dut0_done_hold", 32'(bus0.done), 1);
      check("dut2_vec_hold", 32'(bus2.vec_cnt), 32'(n));
    end
  endtask

  initial begin
    logic [15:0] fr, m, v;
    int          n, ab;
    bit          rm;
    repeat (3) @(negedge clk);
    check("rst_x0", 32'(bus0.x_out), 0);
    check("rst_busy0", 32'(bus0.busy), 0);
    check("rst_done0", 32'(bus0.done), 0);
    check("rst_vec0", 32'(bus0.vec_cnt), 0);
    check("rst_ones0", 32'(bus0.ones_cnt), 0);
    check("rst_x2", 32'(bus2.x_out), 0);
    check("rst_busy2", 32'(bus2.busy), 0);
    check("rst_done2", 32'(bus2.done), 0);
    check("rst_vec2", 32'(bus2.vec_cnt), 0);
    check("rst_ones2", 32'(bus2.ones_cnt), 0);
    rst = 1'b0;
    @(negedge clk);

    run_sweep(16'hFFF0, 16'h0005, 0, 16'h0000, 0, 1'b1, 1'b0);
    run_sweep(16'hFFFF, 16'hA5A5, 1, 16'h0000, 0, 1'b0, 1'b0);
    run_sweep(16'hFFFF, 16'h1234, 1, 16'h0000, 0, 1'b0, 1'b1);
    run_sweep(16'hFC01, 16'h0001, 2, 16'h0000, 0, 1'b1, 1'b0);
    run_sweep(16'h0000, 16'h0000, 1, 16'h0000, 0, 1'b0, 1'b0);
    run_sweep(16'hFF00, 16'h3C00, 3, 16'h00F7, 10, 1'b0, 1'b0);
    run_sweep(16'hFF00, 16'h3C00, 3, 16'h00F7, 0, 1'b0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      fr = 16'($urandom) & 16'($urandom) & 16'($urandom);
      m  = ~fr;
      v  = 16'($urandom);
      n  = 1 << $countones(fr);
      ab = (n >= 4 && $urandom_range(0, 3) == 0) ? int'($urandom_range(2, n - 1)) : 0;
      rm = (ab == 0 && n > 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_sweep(m, v, int'($urandom_range(0, 3)), 16'($urandom), ab, rm, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
